// File: rtl/lb_pkg.sv
// Shared constants and sizing helpers for the line buffer FIFO.
//   DATA_WIDTH_DEF : default word width
//   DEPTH_DEF      : default storage depth in words
//   occ_width()    : bits needed to hold an occupancy of 0..depth
//   ptr_width()    : bits needed to address 0..depth-1
package lb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF      = 64;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_fifo_if.sv
// Data/status bundle between a line buffer FIFO and its user.
//   master : drives flush, wen_in, data_in, ren_in; observes read data and flags
//   slave  : the FIFO side
import lb_pkg::*;

interface line_buffer_fifo_if #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
);
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic                  flush;
    logic                  wen_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ren_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [OCC_W-1:0]      num_words;

    modport master (
        output flush, wen_in, data_in, ren_in,
        input  data_out, valid_out, empty, full, almost_full, num_words
    );

    modport slave (
        input  flush, wen_in, data_in, ren_in,
        output data_out, valid_out, empty, full, almost_full, num_words
    );

endinterface

// File: rtl/lb_mem.sv
// Storage array: one synchronous write port, one registered read port.
//   clk, reset    : clock; reset clears only the read register
//   clk_en        : gates both ports
//   wen/waddr/wdata : write port
//   ren/raddr/rdata : read port, rdata updates the edge after ren
import lb_pkg::*;

module lb_mem #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned ADDR_W     = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (clk_en && wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-edge write to raddr returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (clk_en && ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buffer_fifo.sv
// Line buffer FIFO with clock enable, flush and occupancy flags.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, overrides clk_en and flush
//   clk_en : low freezes pointers, occupancy, read data and valid
//   bus    : flush/write/read requests, registered read data + valid,
//            and empty/full/almost_full/num_words decoded from occupancy
import lb_pkg::*;

module line_buffer_fifo #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned AF_TH      = (DEPTH > 4) ? DEPTH - 4 : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    line_buffer_fifo_if.slave bus
);

    localparam int unsigned     OCC_W    = occ_width(DEPTH);
    localparam int unsigned     PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [OCC_W-1:0] occ, occ_nxt;
    logic             valid, valid_nxt;
    logic             is_empty, is_full;
    logic             wr_accept, rd_accept;

    assign is_empty = (occ == '0);
    assign is_full  = (occ == FULL_OCC);

    // A read frees a slot on the same edge, so a write at full is allowed alongside it.
    assign rd_accept = clk_en & bus.ren_in & ~bus.flush & ~is_empty;
    assign wr_accept = clk_en & bus.wen_in & ~bus.flush & (~is_full | rd_accept);

    // Next-state for pointers, occupancy and read-valid.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        occ_nxt    = occ;
        valid_nxt  = valid;
        if (clk_en) begin
            valid_nxt = rd_accept;
            if (bus.flush) begin
                wr_ptr_nxt = '0;
                rd_ptr_nxt = '0;
                occ_nxt    = '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (rd_accept) begin
                    rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                end
                case ({wr_accept, rd_accept})
                    2'b10:   occ_nxt = occ + OCC_W'(1);
                    2'b01:   occ_nxt = occ - OCC_W'(1);
                    default: occ_nxt = occ;
                endcase
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            valid  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            occ    <= occ_nxt;
            valid  <= valid_nxt;
        end
    end

    lb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .wen    (wr_accept & ~reset),
        .waddr  (wr_ptr),
        .wdata  (bus.data_in),
        .ren    (rd_accept & ~reset),
        .raddr  (rd_ptr),
        .rdata  (bus.data_out)
    );

    assign bus.valid_out   = valid;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (32'(occ) >= AF_TH);
    assign bus.num_words   = occ;

endmodule

// File: tb/tb_line_buffer_fifo.sv
// Directed bench for line_buffer_fifo: a 64-deep instance for ordering,
// full/almost-full, flush, clock-enable and reset behaviour, and a 6-deep
// instance for pointer wrap with a scoreboard.
module tb_line_buffer_fifo;

    logic clk;
    logic reset;
    logic clk_en;

    int n_checks = 0;
    int n_errors = 0;

    line_buffer_fifo_if #(.DATA_WIDTH(16), .DEPTH(64)) if64 ();
    line_buffer_fifo_if #(.DATA_WIDTH(16), .DEPTH(6))  if6 ();

    line_buffer_fifo #(.DATA_WIDTH(16), .DEPTH(64)) dut64 (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (if64)
    );

    line_buffer_fifo #(.DATA_WIDTH(16), .DEPTH(6)) dut6 (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (if6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sb [$];
    logic [15:0] exp_word;
    logic [15:0] wval;
    int          tgt;

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        if64.flush = 1'b0; if64.wen_in = 1'b0; if64.ren_in = 1'b0; if64.data_in = '0;
        if6.flush  = 1'b0; if6.wen_in  = 1'b0; if6.ren_in  = 1'b0; if6.data_in  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_empty",  32'(if64.empty),       1);
        check("rst_full",   32'(if64.full),        0);
        check("rst_af",     32'(if64.almost_full), 0);
        check("rst_num",    32'(if64.num_words),   0);
        check("rst_data",   32'(if64.data_out),    0);
        check("rst_valid",  32'(if64.valid_out),   0);
        check("rst6_empty", 32'(if6.empty),        1);

        // Five writes then five reads, in order
        for (int i = 1; i <= 5; i++) begin
            if64.wen_in = 1'b1; if64.data_in = 16'(i);
            tick();
        end
        if64.wen_in = 1'b0;
        check("seq_num", 32'(if64.num_words), 5);
        if64.ren_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("seq_valid", 32'(if64.valid_out), 1);
            check("seq_data",  32'(if64.data_out),  32'(i));
        end
        check("seq_empty", 32'(if64.empty), 1);
        if64.ren_in = 1'b0;
        tick();
        check("idle_valid", 32'(if64.valid_out), 0);
        check("idle_hold",  32'(if64.data_out),  5);

        // Fill to full, watch almost_full threshold, drop overflow write
        for (int i = 0; i < 64; i++) begin
            if64.wen_in = 1'b1; if64.data_in = 16'(16'h0100 + i);
            tick();
            check("fill_af", 32'(if64.almost_full), 32'((i + 1) >= 60));
        end
        check("fill_full", 32'(if64.full),      1);
        check("fill_num",  32'(if64.num_words), 64);
        if64.data_in = 16'hDEAD;
        tick();
        if64.wen_in = 1'b0;
        check("ovf_num",  32'(if64.num_words), 64);
        check("ovf_full", 32'(if64.full),      1);
        if64.ren_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            check("drain_valid", 32'(if64.valid_out), 1);
            check("drain_data",  32'(if64.data_out),  32'(16'h0100 + i));
        end
        if64.ren_in = 1'b0;
        check("drain_empty", 32'(if64.empty), 1);

        // Simultaneous write+read at full
        for (int i = 0; i < 64; i++) begin
            if64.wen_in = 1'b1; if64.data_in = 16'(16'h0200 + i);
            tick();
        end
        if64.ren_in = 1'b1; if64.data_in = 16'hBEEF;
        tick();
        if64.wen_in = 1'b0;
        check("wr_rd_full_num",  32'(if64.num_words), 64);
        check("wr_rd_full_full", 32'(if64.full),      1);
        check("wr_rd_full_data", 32'(if64.data_out),  32'h0200);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i < 64) check("beef_order", 32'(if64.data_out), 32'(16'h0200 + i));
            else        check("beef_last",  32'(if64.data_out), 32'hBEEF);
        end
        if64.ren_in = 1'b0;
        check("beef_empty", 32'(if64.empty), 1);

        // Flush overrides same-edge write and read
        for (int i = 0; i < 3; i++) begin
            if64.wen_in = 1'b1; if64.data_in = 16'(16'h0031 + i);
            tick();
        end
        if64.flush = 1'b1; if64.ren_in = 1'b1; if64.data_in = 16'h0077;
        tick();
        if64.flush = 1'b0; if64.wen_in = 1'b0;
        check("flush_num",   32'(if64.num_words), 0);
        check("flush_empty", 32'(if64.empty),     1);
        check("flush_valid", 32'(if64.valid_out), 0);
        tick();
        if64.ren_in = 1'b0;
        check("flush_rd_valid", 32'(if64.valid_out), 0);
        check("flush_rd_num",   32'(if64.num_words), 0);

        // Clock enable freeze, then mid-stream reset
        for (int i = 0; i < 3; i++) begin
            if64.wen_in = 1'b1; if64.data_in = 16'(16'h0041 + i);
            tick();
        end
        if64.wen_in = 1'b0; if64.ren_in = 1'b1;
        tick();
        check("pre_ce_data", 32'(if64.data_out),  32'h0041);
        check("pre_ce_num",  32'(if64.num_words), 2);
        clk_en = 1'b0; if64.wen_in = 1'b1; if64.data_in = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_num",   32'(if64.num_words), 2);
            check("ce_data",  32'(if64.data_out),  32'h0041);
            check("ce_valid", 32'(if64.valid_out), 1);
        end
        clk_en = 1'b1; if64.wen_in = 1'b0;
        tick();
        check("post_ce_data", 32'(if64.data_out),  32'h0042);
        check("post_ce_num",  32'(if64.num_words), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_empty", 32'(if64.empty),     1);
        check("mid_rst_data",  32'(if64.data_out),  0);
        check("mid_rst_valid", 32'(if64.valid_out), 0);
        check("mid_rst_num",   32'(if64.num_words), 0);
        tick();
        if64.ren_in = 1'b0;
        check("mid_rst_rd_valid", 32'(if64.valid_out), 0);

        // 6-deep wrap with scoreboard: fill to 1..6, one wr+rd, drain
        wval = 16'h0600;
        for (int k = 0; k < 20; k++) begin
            tgt = (k % 6) + 1;
            if6.wen_in = 1'b1;
            while (sb.size() < tgt) begin
                if6.data_in = wval;
                sb.push_back(wval);
                wval = wval + 16'd1;
                tick();
            end
            if6.wen_in = 1'b0;
            check("w6_num",  32'(if6.num_words), 32'(tgt));
            check("w6_full", 32'(if6.full),      32'(tgt == 6));
            if (tgt == 6) begin
                if6.wen_in = 1'b1; if6.data_in = 16'hDEAD;
                tick();
                if6.wen_in = 1'b0;
                check("w6_ovf_num", 32'(if6.num_words), 6);
            end
            exp_word = sb.pop_front();
            if6.wen_in = 1'b1; if6.ren_in = 1'b1; if6.data_in = wval;
            sb.push_back(wval);
            wval = wval + 16'd1;
            tick();
            if6.wen_in = 1'b0;
            check("w6_wr_rd_num",  32'(if6.num_words), 32'(tgt));
            check("w6_wr_rd_data", 32'(if6.data_out),  32'(exp_word));
            while (sb.size() > 0) begin
                exp_word = sb.pop_front();
                tick();
                check("w6_rd_valid", 32'(if6.valid_out), 1);
                check("w6_rd_data",  32'(if6.data_out),  32'(exp_word));
            end
            tick();
            if6.ren_in = 1'b0;
            check("w6_udf_valid", 32'(if6.valid_out), 0);
            check("w6_udf_empty", 32'(if6.empty),     1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
